// File: rtl/sig_gen_sweep_ctrl_pkg.sv
// Shared definitions for the sine-generator sweep controller: FSM encoding
// and the bit layout of one packed sweep-table entry.
package sig_gen_sweep_ctrl_pkg;

    localparam int FIELD_W   = 32;
    localparam int AMPL_OFS  = 0;
    localparam int FREQ_OFS  = AMPL_OFS  + FIELD_W;
    localparam int PHASE_OFS = FREQ_OFS  + FIELD_W;
    localparam int OFFS_OFS  = PHASE_OFS + FIELD_W;
    localparam int DWELL_OFS = OFFS_OFS  + FIELD_W;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4
    } sweep_state_e;

    function automatic int entry_width(input int dwell_w);
        return DWELL_OFS + dwell_w;
    endfunction

endpackage

// File: rtl/sig_gen_sweep_table.sv
// Sweep parameter table: DEPTH packed entries, one write port, combinational read.
module sig_gen_sweep_table
    import sig_gen_sweep_ctrl_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int ENTRY_W = entry_width(32)
) (
    input  logic               clk_i,
    input  logic               wr_en_i,
    input  logic [ADDR_W-1:0]  wr_addr_i,
    input  logic [ENTRY_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0]  rd_addr_i,
    output logic [ENTRY_W-1:0] rd_data_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic               addr_ok;

    // Out-of-range addresses only exist when DEPTH is not a power of two.
    assign addr_ok = {1'b0, wr_addr_i} < (ADDR_W+1)'(DEPTH);

    always_ff @(posedge clk_i) begin
        if (wr_en_i && addr_ok) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/sig_gen_sweep_ctrl.sv
// Steps a sine generator through a programmed parameter table: settle in reset,
// run for the dwell time, advance. Optional SIG_GEN_SWEEP_LOOP_EN adds looping.
module sig_gen_sweep_ctrl
    import sig_gen_sweep_ctrl_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int ADDR_W        = $clog2(DEPTH),
    parameter int DWELL_W       = 32,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic               Clk_i,
    input  logic               nReset_i,
    input  logic               Wr_En_i,
    input  logic [ADDR_W-1:0]  Wr_Addr_i,
    input  logic [31:0]        Wr_Ampl_mV_i,
    input  logic [31:0]        Wr_Freq_Hz_i,
    input  logic [31:0]        Wr_Phase_Deg_i,
    input  logic [31:0]        Wr_Offset_muV_i,
    input  logic [DWELL_W-1:0] Wr_Dwell_i,
    input  logic [ADDR_W:0]    Num_Steps_i,
    input  logic               Run_i,
    input  logic               Stop_i,
`ifdef SIG_GEN_SWEEP_LOOP_EN
    input  logic               Loop_i,
    output logic [15:0]        Loop_Cnt_o,
`endif
    output logic               Gen_nReset_o,
    output logic               Gen_Start_o,
    output logic [31:0]        Ampl_mV_o,
    output logic [31:0]        Freq_Hz_o,
    output logic [31:0]        Phase_Deg_o,
    output logic [31:0]        Offset_muV_o,
    output logic [ADDR_W-1:0]  Step_Idx_o,
    output logic               Busy_o,
    output logic               Done_o
);

    localparam int ENTRY_W  = entry_width(DWELL_W);
    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);

    sweep_state_e        state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W:0]     nsteps_q, nsteps_d, nsteps_in;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [DWELL_W-1:0]  dwell_cnt_q, dwell_cnt_d;
    logic [31:0]         ampl_q, ampl_d, freq_q, freq_d;
    logic [31:0]         phase_q, phase_d, offs_q, offs_d;
    logic [ENTRY_W-1:0]  wr_data, rd_data;
    logic [DWELL_W-1:0]  rd_dwell;
    logic                busy, last_step, wrap_en;

`ifdef SIG_GEN_SWEEP_LOOP_EN
    logic        loop_q, loop_d;
    logic [15:0] loop_cnt_q, loop_cnt_d;
    assign wrap_en    = loop_q;
    assign Loop_Cnt_o = loop_cnt_q;
`else
    assign wrap_en = 1'b0;
`endif

    assign busy    = (state_q == ST_LOAD) || (state_q == ST_SETTLE) || (state_q == ST_RUN);
    assign wr_data = {Wr_Dwell_i, Wr_Offset_muV_i, Wr_Phase_Deg_i, Wr_Freq_Hz_i, Wr_Ampl_mV_i};

    sig_gen_sweep_table #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .ENTRY_W(ENTRY_W)
    ) u_table (
        .clk_i    (Clk_i),
        .wr_en_i  (Wr_En_i && !busy),
        .wr_addr_i(Wr_Addr_i),
        .wr_data_i(wr_data),
        .rd_addr_i(idx_q),
        .rd_data_o(rd_data)
    );

    assign rd_dwell  = rd_data[DWELL_OFS +: DWELL_W];
    assign nsteps_in = (Num_Steps_i > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : Num_Steps_i;
    assign last_step = ({1'b0, idx_q} + (ADDR_W+1)'(1)) == nsteps_q;

    always_ff @(posedge Clk_i or negedge nReset_i) begin
        if (!nReset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (Run_i && !Stop_i) begin
                    state_d = (nsteps_in == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD:   state_d = Stop_i ? ST_IDLE : ST_SETTLE;
            ST_SETTLE: begin
                if (Stop_i)                  state_d = ST_IDLE;
                else if (settle_cnt_q == '0) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (Stop_i) begin
                    state_d = ST_IDLE;
                end else if (dwell_cnt_q == DWELL_W'(1)) begin
                    state_d = (last_step && !wrap_en) ? ST_DONE : ST_LOAD;
                end
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        Gen_nReset_o = (state_q == ST_RUN);
        Gen_Start_o  = (state_q == ST_RUN);
        Busy_o       = busy;
        Done_o       = (state_q == ST_DONE);
        Ampl_mV_o    = ampl_q;
        Freq_Hz_o    = freq_q;
        Phase_Deg_o  = phase_q;
        Offset_muV_o = offs_q;
        Step_Idx_o   = idx_q;
    end

    always_comb begin
        idx_d        = idx_q;
        nsteps_d     = nsteps_q;
        settle_cnt_d = settle_cnt_q;
        dwell_cnt_d  = dwell_cnt_q;
        ampl_d       = ampl_q;
        freq_d       = freq_q;
        phase_d      = phase_q;
        offs_d       = offs_q;
`ifdef SIG_GEN_SWEEP_LOOP_EN
        loop_d       = loop_q;
        loop_cnt_d   = loop_cnt_q;
`endif
        if (state_q == ST_IDLE && state_d == ST_LOAD) begin
            idx_d    = '0;
            nsteps_d = nsteps_in;
`ifdef SIG_GEN_SWEEP_LOOP_EN
            loop_d     = Loop_i;
            loop_cnt_d = '0;
`endif
        end
        // A stop during LOAD leaves the previous step's parameters visible.
        if (state_q == ST_LOAD && state_d == ST_SETTLE) begin
            ampl_d       = rd_data[AMPL_OFS  +: FIELD_W];
            freq_d       = rd_data[FREQ_OFS  +: FIELD_W];
            phase_d      = rd_data[PHASE_OFS +: FIELD_W];
            offs_d       = rd_data[OFFS_OFS  +: FIELD_W];
            dwell_cnt_d  = (rd_dwell == '0) ? DWELL_W'(1) : rd_dwell;
            settle_cnt_d = SETTLE_W'(SETTLE_CYCLES - 1);
        end
        if (state_q == ST_SETTLE && settle_cnt_q != '0) begin
            settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
        end
        if (state_q == ST_RUN) begin
            dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
            if (state_d == ST_LOAD) begin
                idx_d = last_step ? '0 : idx_q + ADDR_W'(1);
`ifdef SIG_GEN_SWEEP_LOOP_EN
                if (last_step && loop_cnt_q != 16'hFFFF) begin
                    loop_cnt_d = loop_cnt_q + 16'd1;
                end
`endif
            end
        end
    end

    always_ff @(posedge Clk_i or negedge nReset_i) begin
        if (!nReset_i) begin
            idx_q        <= '0;
            nsteps_q     <= '0;
            settle_cnt_q <= '0;
            dwell_cnt_q  <= '0;
            ampl_q       <= '0;
            freq_q       <= '0;
            phase_q      <= '0;
            offs_q       <= '0;
`ifdef SIG_GEN_SWEEP_LOOP_EN
            loop_q       <= 1'b0;
            loop_cnt_q   <= '0;
`endif
        end else begin
            idx_q        <= idx_d;
            nsteps_q     <= nsteps_d;
            settle_cnt_q <= settle_cnt_d;
            dwell_cnt_q  <= dwell_cnt_d;
            ampl_q       <= ampl_d;
            freq_q       <= freq_d;
            phase_q      <= phase_d;
            offs_q       <= offs_d;
`ifdef SIG_GEN_SWEEP_LOOP_EN
            loop_q       <= loop_d;
            loop_cnt_q   <= loop_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_sig_gen_sweep_ctrl.sv
// Directed self-checking bench for sig_gen_sweep_ctrl (loop test only when
// SIG_GEN_SWEEP_LOOP_EN is defined).
module tb_sig_gen_sweep_ctrl;

    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;
    localparam int DWELL_W = 32;

    logic               Clk_i, nReset_i, Wr_En_i, Run_i, Stop_i;
    logic [ADDR_W-1:0]  Wr_Addr_i;
    logic [31:0]        Wr_Ampl_mV_i, Wr_Freq_Hz_i, Wr_Phase_Deg_i, Wr_Offset_muV_i;
    logic [DWELL_W-1:0] Wr_Dwell_i;
    logic [ADDR_W:0]    Num_Steps_i;
    logic               Gen_nReset_o, Gen_Start_o, Busy_o, Done_o;
    logic [31:0]        Ampl_mV_o, Freq_Hz_o, Phase_Deg_o, Offset_muV_o;
    logic [ADDR_W-1:0]  Step_Idx_o;
`ifdef SIG_GEN_SWEEP_LOOP_EN
    logic               Loop_i;
    logic [15:0]        Loop_Cnt_o;
`endif

    int err_cnt = 0;
    int chk_cnt = 0;

    sig_gen_sweep_ctrl #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DWELL_W(DWELL_W), .SETTLE_CYCLES(4)
    ) dut (
        .Clk_i(Clk_i), .nReset_i(nReset_i), .Wr_En_i(Wr_En_i), .Wr_Addr_i(Wr_Addr_i),
        .Wr_Ampl_mV_i(Wr_Ampl_mV_i), .Wr_Freq_Hz_i(Wr_Freq_Hz_i),
        .Wr_Phase_Deg_i(Wr_Phase_Deg_i), .Wr_Offset_muV_i(Wr_Offset_muV_i),
        .Wr_Dwell_i(Wr_Dwell_i), .Num_Steps_i(Num_Steps_i), .Run_i(Run_i), .Stop_i(Stop_i),
`ifdef SIG_GEN_SWEEP_LOOP_EN
        .Loop_i(Loop_i), .Loop_Cnt_o(Loop_Cnt_o),
`endif
        .Gen_nReset_o(Gen_nReset_o), .Gen_Start_o(Gen_Start_o),
        .Ampl_mV_o(Ampl_mV_o), .Freq_Hz_o(Freq_Hz_o), .Phase_Deg_o(Phase_Deg_o),
        .Offset_muV_o(Offset_muV_o), .Step_Idx_o(Step_Idx_o), .Busy_o(Busy_o), .Done_o(Done_o)
    );

    initial Clk_i = 1'b0;
    always #5 Clk_i = ~Clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk_i);
        #1;
    endtask

    task automatic wr_entry(input logic [ADDR_W-1:0] a, input logic [31:0] am, input logic [31:0] fr,
                            input logic [31:0] ph, input logic [31:0] of, input logic [DWELL_W-1:0] dw);
        Wr_En_i = 1'b1; Wr_Addr_i = a;
        Wr_Ampl_mV_i = am; Wr_Freq_Hz_i = fr; Wr_Phase_Deg_i = ph; Wr_Offset_muV_i = of; Wr_Dwell_i = dw;
        tick();
        Wr_En_i = 1'b0;
    endtask

    // After return the DUT has sampled Run_i: cycle index 0 is LOAD (or DONE).
    task automatic start_run(input logic [ADDR_W:0] n);
        Num_Steps_i = n; Run_i = 1'b1;
        tick();
        Run_i = 1'b0;
    endtask

    logic [63:0] st_v, dn_v, bz_v, nr_v;

    initial begin
        nReset_i = 1'b0; Wr_En_i = 1'b0; Run_i = 1'b0; Stop_i = 1'b0; Wr_Addr_i = '0;
        Wr_Ampl_mV_i = '0; Wr_Freq_Hz_i = '0; Wr_Phase_Deg_i = '0; Wr_Offset_muV_i = '0;
        Wr_Dwell_i = '0; Num_Steps_i = '0;
`ifdef SIG_GEN_SWEEP_LOOP_EN
        Loop_i = 1'b0;
`endif
        #3;
        chk("rst_gen_nreset", Gen_nReset_o, 0);
        chk("rst_start", Gen_Start_o, 0);
        chk("rst_busy", Busy_o, 0);
        chk("rst_done", Done_o, 0);
        chk("rst_ampl", Ampl_mV_o, 0);
        chk("rst_idx", Step_Idx_o, 0);
        repeat (2) @(posedge Clk_i);
        #2 nReset_i = 1'b1;
        tick();

        // Two-step sweep
        wr_entry(0, 1000, 50, 0, 0, 10);
        wr_entry(1, 2000, 100, 90, 500, 5);
        start_run(2);
        st_v = '0; dn_v = '0; bz_v = '0; nr_v = '0;
        for (int i = 0; i < 30; i++) begin
            st_v[i] = Gen_Start_o; dn_v[i] = Done_o; bz_v[i] = Busy_o; nr_v[i] = Gen_nReset_o;
            if (i == 10) begin
                chk("s0_ampl", Ampl_mV_o, 1000);
                chk("s0_freq", Freq_Hz_o, 50);
                chk("s0_phase", Phase_Deg_o, 0);
                chk("s0_idx", Step_Idx_o, 0);
            end
            if (i == 22) begin
                chk("s1_ampl", Ampl_mV_o, 2000);
                chk("s1_freq", Freq_Hz_o, 100);
                chk("s1_phase", Phase_Deg_o, 90);
                chk("s1_offs", Offset_muV_o, 500);
                chk("s1_idx", Step_Idx_o, 1);
            end
            tick();
        end
        chk("sweep_start", st_v, (64'h3FF << 5) | (64'h1F << 20));
        chk("sweep_nreset", nr_v, (64'h3FF << 5) | (64'h1F << 20));
        chk("sweep_done", dn_v, 64'h1 << 25);
        chk("sweep_busy", bz_v, 64'h1FF_FFFF);

        // Stop on third RUN cycle of step 0
        start_run(2);
        repeat (7) tick();
        chk("stop_pre_start", Gen_Start_o, 1);
        Stop_i = 1'b1;
        tick();
        Stop_i = 1'b0;
        chk("stop_start", Gen_Start_o, 0);
        chk("stop_nreset", Gen_nReset_o, 0);
        chk("stop_busy", Busy_o, 0);
        chk("stop_done", Done_o, 0);
        chk("stop_ampl_hold", Ampl_mV_o, 1000);
        tick();
        chk("stop_done2", Done_o, 0);

        // Zero steps
        start_run(0);
        chk("zero_done", Done_o, 1);
        chk("zero_busy", Busy_o, 0);
        chk("zero_start", Gen_Start_o, 0);
        tick();
        chk("zero_done_end", Done_o, 0);

        // Dwell 0 and write while busy
        wr_entry(0, 3000, 60, 45, 0, 0);
        start_run(1);
        st_v = '0; dn_v = '0;
        for (int i = 0; i < 10; i++) begin
            st_v[i] = Gen_Start_o; dn_v[i] = Done_o;
            if (i == 2) begin
                Wr_En_i = 1'b1; Wr_Addr_i = 1; Wr_Ampl_mV_i = 9999; Wr_Freq_Hz_i = 7;
                Wr_Phase_Deg_i = 7; Wr_Offset_muV_i = 7; Wr_Dwell_i = 7;
            end
            if (i == 3) Wr_En_i = 1'b0;
            tick();
        end
        chk("dw0_start", st_v, 64'h1 << 5);
        chk("dw0_done", dn_v, 64'h1 << 6);
        start_run(2);
        st_v = '0;
        for (int i = 0; i < 18; i++) begin
            st_v[i] = Gen_Start_o;
            if (i == 12) begin
                chk("busywr_ampl", Ampl_mV_o, 2000);
                chk("busywr_freq", Freq_Hz_o, 100);
            end
            tick();
        end
        chk("busywr_start", st_v, (64'h1 << 5) | (64'h1F << 11));

        // Asynchronous reset mid-SETTLE
        start_run(1);
        tick(); tick();
        chk("ar_ampl_pre", Ampl_mV_o, 3000);
        chk("ar_busy_pre", Busy_o, 1);
        #2 nReset_i = 1'b0;
        #1;
        chk("ar_busy", Busy_o, 0);
        chk("ar_nreset", Gen_nReset_o, 0);
        chk("ar_start", Gen_Start_o, 0);
        chk("ar_ampl", Ampl_mV_o, 0);
        chk("ar_freq", Freq_Hz_o, 0);
        chk("ar_done", Done_o, 0);
        #2 nReset_i = 1'b1;
        tick();
        chk("ar_idle_busy", Busy_o, 0);
        start_run(1);
        chk("ar_rerun_busy", Busy_o, 1);
        repeat (5) tick();
        chk("ar_rerun_start", Gen_Start_o, 1);
        tick();
        chk("ar_rerun_done", Done_o, 1);
        tick();

`ifdef SIG_GEN_SWEEP_LOOP_EN
        wr_entry(0, 1000, 50, 0, 0, 2);
        Loop_i = 1'b1;
        start_run(2);
        Loop_i = 1'b0;
        dn_v = '0;
        for (int i = 0; i < 36; i++) begin
            dn_v[i] = Done_o;
            if (i == 5)  chk("loop_idx_a", Step_Idx_o, 0);
            if (i == 12) chk("loop_idx_b", Step_Idx_o, 1);
            if (i == 22) chk("loop_idx_c", Step_Idx_o, 0);
            if (i == 29) chk("loop_idx_d", Step_Idx_o, 1);
            if (i == 35) chk("loop_cnt", Loop_Cnt_o, 2);
            tick();
        end
        Stop_i = 1'b1;
        tick();
        Stop_i = 1'b0;
        dn_v[36] = Done_o;
        chk("loop_stop_busy", Busy_o, 0);
        chk("loop_no_done", dn_v, 0);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
